// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : link_pkg
//  Purpose  : Shared definitions for the parallel pixel link: GPIO0 bit map,
//             panel geometry and the transmitter FSM state encoding. Also
//             imported by the display-controller side of the link.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package link_pkg;

    localparam int LINK_BUS_W     = 30;
    localparam int LINK_DATA_LSB  = 0;
    localparam int LINK_DATA_W    = 16;
    localparam int LINK_WCLK_BIT  = 24;
    localparam int LINK_HSYNC_BIT = 25;
    localparam int LINK_VSYNC_BIT = 26;

    localparam int DISP_WIDTH     = 480;
    localparam int DISP_HEIGHT    = 272;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_VS_LO    = 4'd1,
        ST_VS_HI    = 4'd2,
        ST_WAIT_PIX = 4'd3,
        ST_SETUP    = 4'd4,
        ST_CLK_LO   = 4'd5,
        ST_CLK_HI   = 4'd6,
        ST_HS_LO    = 4'd7,
        ST_HS_HI    = 4'd8,
        ST_DONE     = 4'd9
    } link_state_e;

endpackage
`default_nettype wire

// File: rtl/pixel_link_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_link_transmitter_if
//  Purpose  : Bundles the pixel stream, frame control and GPIO0 link bus of
//             the pixel link transmitter.
//  Ports    : iStart, iPixelValid, iPixelData  (source -> transmitter)
//             oPixelReady, oGPIO0, oBusy, oFrameDone (transmitter -> source)
//             modport master : transmitter side
//             modport slave  : pixel source / frame requester side
//  Revision : 1.0  initial release
// ============================================================================
interface pixel_link_transmitter_if;

    logic                                          iStart;
    logic                                          iPixelValid;
    logic [link_pkg::LINK_DATA_W-1:0]              iPixelData;
    logic                                          oPixelReady;
    logic [link_pkg::LINK_BUS_W-1:0]               oGPIO0;
    logic                                          oBusy;
    logic                                          oFrameDone;

    modport master (
        input  iStart, iPixelValid, iPixelData,
        output oPixelReady, oGPIO0, oBusy, oFrameDone
    );

    modport slave (
        output iStart, iPixelValid, iPixelData,
        input  oPixelReady, oGPIO0, oBusy, oFrameDone
    );

endinterface
`default_nettype wire

// File: rtl/link_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : link_phase_timer
//  Purpose  : Phase duration timer. A load starts a PHASE-cycle interval;
//             expire_o is high on the last cycle of the interval. A load in
//             the expiring cycle chains the next phase with no gap.
//  Ports    : clk_i    in  clock
//             rst_i    in  synchronous active-high reset
//             load_i   in  start a new interval (wins over counting)
//             expire_o out last cycle of the running interval
//  Revision : 1.0  initial release
// ============================================================================
module link_phase_timer #(
    parameter int PHASE = 8
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic load_i,
    output logic      expire_o
);

    localparam int CW = $clog2(PHASE + 1);

    logic [CW-1:0] cnt_q;
    logic          run_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= CW'(PHASE - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign expire_o = run_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_link_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_link_transmitter
//  Purpose  : Serialises one H_PIXELS x V_LINES RGB565 frame per start
//             request onto the GPIO0 parallel link: vsync pulse, then per
//             pixel data setup / wclk low / wclk high, with an hsync pulse
//             between lines. Strobes are active-low and never overlap.
//  Ports    : iCLOCKA in  clock
//             iRESET  in  synchronous active-high reset
//             link    master modport of pixel_link_transmitter_if
//  Revision : 1.0  initial release
// ============================================================================
module pixel_link_transmitter
    import link_pkg::*;
#(
    parameter int H_PIXELS = DISP_WIDTH,
    parameter int V_LINES  = DISP_HEIGHT,
    parameter int PHASE    = 8
) (
    input  wire logic                 iCLOCKA,
    input  wire logic                 iRESET,
    pixel_link_transmitter_if.master  link
);

    localparam logic [8:0] H_LAST = 9'(H_PIXELS - 1);
    localparam logic [8:0] V_LAST = 9'(V_LINES - 1);

    link_state_e              state_q, state_d;
    logic [8:0]               h_q, h_d;
    logic [8:0]               v_q, v_d;
    logic [LINK_DATA_W-1:0]   data_q, data_d;
    logic                     load_w;
    logic                     expire_w;
    logic                     ready_w;

    link_phase_timer #(.PHASE(PHASE)) u_timer (
        .clk_i    (iCLOCKA),
        .rst_i    (iRESET),
        .load_i   (load_w),
        .expire_o (expire_w)
    );

    always_ff @(posedge iCLOCKA) begin
        if (iRESET) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            data_q  <= data_d;
        end
    end

    // Every transition into a timed state loads the timer in the same cycle,
    // so each timed state lasts exactly PHASE cycles.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        data_d  = data_q;
        load_w  = 1'b0;
        ready_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (link.iStart) begin
                    state_d = ST_VS_LO;
                    load_w  = 1'b1;
                    h_d     = '0;
                    v_d     = '0;
                end
            end
            ST_VS_LO: begin
                if (expire_w) begin
                    state_d = ST_VS_HI;
                    load_w  = 1'b1;
                end
            end
            ST_VS_HI: begin
                if (expire_w) state_d = ST_WAIT_PIX;
            end
            ST_WAIT_PIX: begin
                // Only place the data bus may change; wclk is high here.
                if (link.iPixelValid) begin
                    ready_w = 1'b1;
                    data_d  = link.iPixelData;
                    state_d = ST_SETUP;
                    load_w  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (expire_w) begin
                    state_d = ST_CLK_LO;
                    load_w  = 1'b1;
                end
            end
            ST_CLK_LO: begin
                if (expire_w) begin
                    state_d = ST_CLK_HI;
                    load_w  = 1'b1;
                end
            end
            ST_CLK_HI: begin
                if (expire_w) begin
                    if (h_q == H_LAST) begin
                        h_d = '0;
                        // No hsync after the last line, so the receiver's
                        // line pointer never steps past the frame.
                        if (v_q == V_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            v_d     = v_q + 9'd1;
                            state_d = ST_HS_LO;
                            load_w  = 1'b1;
                        end
                    end else begin
                        h_d     = h_q + 9'd1;
                        state_d = ST_WAIT_PIX;
                    end
                end
            end
            ST_HS_LO: begin
                if (expire_w) begin
                    state_d = ST_HS_HI;
                    load_w  = 1'b1;
                end
            end
            ST_HS_HI: begin
                if (expire_w) state_d = ST_WAIT_PIX;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register, so each one is low
    // for exactly the cycles its LO state is resident.
    always_comb begin
        link.oGPIO0                                        = '0;
        link.oGPIO0[LINK_DATA_LSB +: LINK_DATA_W]          = data_q;
        link.oGPIO0[LINK_WCLK_BIT]                         = (state_q != ST_CLK_LO);
        link.oGPIO0[LINK_HSYNC_BIT]                        = (state_q != ST_HS_LO);
        link.oGPIO0[LINK_VSYNC_BIT]                        = (state_q != ST_VS_LO);
    end

    assign link.oPixelReady = ready_w;
    assign link.oBusy       = (state_q != ST_IDLE);
    assign link.oFrameDone  = (state_q == ST_DONE);

endmodule
`default_nettype wire
